// File: rtl/dmem_bus_pkg.sv
// rtl/dmem_bus_pkg.sv - shared MMIO offsets, register bit indices, region decode type and byte-lane merge
package dmem_bus_pkg;

   // Word-aligned byte offsets inside the 64-byte MMIO window
   localparam logic [5:0] MMIO_GPIO        = 6'h00;
   localparam logic [5:0] MMIO_MTIME_LO    = 6'h04;
   localparam logic [5:0] MMIO_MTIME_HI    = 6'h08;
   localparam logic [5:0] MMIO_MTIMECMP_LO = 6'h0C;
   localparam logic [5:0] MMIO_MTIMECMP_HI = 6'h10;
   localparam logic [5:0] MMIO_CTRL        = 6'h14;
   localparam logic [5:0] MMIO_STATUS      = 6'h18;

   localparam int CTRL_IRQ_EN_BIT    = 0;
   localparam int STATUS_PENDING_BIT = 0;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_MMIO,
      REG_NONE
   } region_e;

   // Replace only the byte lanes whose strobe is set
   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dmem_bus_mtimer.sv
// rtl/dmem_bus_mtimer.sv - prescaled 64-bit machine timer with compare, irq enable and sticky pending
// Ports: clk, reset (async, active-high); we/offset/wdata/wstrb register write port;
//        rdata combinational read of the register at offset; irq = pending & irq_en.
module dmem_bus_mtimer
   import dmem_bus_pkg::*;
#(
   parameter int TickDiv = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [5:0]  offset,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam int            PW        = (TickDiv > 1) ? $clog2(TickDiv) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TickDiv - 1);

   logic [PW-1:0] presc;
   logic [63:0]   mtime;
   logic [63:0]   mtimecmp;
   logic          irq_en;
   logic          pending;

   logic tick;
   logic wr_lo, wr_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;
   logic clr_pend, set_pend;

   assign tick      = (presc == PRESC_MAX);
   assign wr_lo     = we && (offset == MMIO_MTIME_LO);
   assign wr_hi     = we && (offset == MMIO_MTIME_HI);
   assign wr_cmp_lo = we && (offset == MMIO_MTIMECMP_LO);
   assign wr_cmp_hi = we && (offset == MMIO_MTIMECMP_HI);
   assign wr_ctrl   = we && (offset == MMIO_CTRL) && wstrb[0];
   assign clr_pend  = we && (offset == MMIO_STATUS) && wstrb[0] && wdata[STATUS_PENDING_BIT];
   // Compare uses registered values only, so irq has no combinational path from the bus
   assign set_pend  = (mtime >= mtimecmp);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc    <= '0;
         mtime    <= '0;
         mtimecmp <= '1;
         irq_en   <= 1'b0;
         pending  <= 1'b0;
      end else begin
         presc <= tick ? '0 : presc + PW'(1);
         // A write to either half suppresses the increment for the whole register
         if (wr_lo)
            mtime[31:0] <= apply_wstrb(mtime[31:0], wdata, wstrb);
         else if (wr_hi)
            mtime[63:32] <= apply_wstrb(mtime[63:32], wdata, wstrb);
         else if (tick)
            mtime <= mtime + 64'd1;
         if (wr_cmp_lo) mtimecmp[31:0]  <= apply_wstrb(mtimecmp[31:0], wdata, wstrb);
         if (wr_cmp_hi) mtimecmp[63:32] <= apply_wstrb(mtimecmp[63:32], wdata, wstrb);
         if (wr_ctrl)   irq_en <= wdata[CTRL_IRQ_EN_BIT];
         // Set beats a simultaneous clear
         pending <= set_pend | (pending & ~clr_pend);
      end
   end

   always_comb begin
      rdata = '0;
      case (offset)
         MMIO_MTIME_LO:    rdata = mtime[31:0];
         MMIO_MTIME_HI:    rdata = mtime[63:32];
         MMIO_MTIMECMP_LO: rdata = mtimecmp[31:0];
         MMIO_MTIMECMP_HI: rdata = mtimecmp[63:32];
         MMIO_CTRL:        rdata[CTRL_IRQ_EN_BIT] = irq_en;
         MMIO_STATUS:      rdata[STATUS_PENDING_BIT] = pending;
         default:          rdata = '0;
      endcase
   end

   assign irq = pending & irq_en;

endmodule

// File: rtl/dmem_bus.sv
// rtl/dmem_bus.sv - data-side bus: address decode, word RAM, GPIO register, timer and bus error flag
// Ports: clk, reset (async, active-high); d_addr/d_wdata/d_wstrb from core, d_rdata combinational;
//        gpio_out register value, timer_irq level, bus_err one-cycle pulse after an unmapped access.
module dmem_bus
   import dmem_bus_pkg::*;
#(
   parameter logic [31:0] RamBase  = 32'h1000_0000,
   parameter int          RamWords = 1024,
   parameter logic [31:0] MmioBase = 32'h8000_0000,
   parameter int          TickDiv  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic [31:0] d_rdata,
   output logic [31:0] gpio_out,
   output logic        timer_irq,
   output logic        bus_err
);

   localparam int          IW        = $clog2(RamWords);
   localparam logic [31:0] RAM_BYTES = 32'(4 * RamWords);

   logic [31:0] ram_off;
   logic [31:0] mmio_off;
   logic [5:0]  mmio_word;
   logic [IW-1:0] idx;
   region_e     region;
   logic        ram_we, mmio_we, err_now;
   logic [31:0] timer_rdata;
   logic [31:0] mem [RamWords];

   // Subtract-then-compare keeps the upper bound free of overflow
   assign ram_off   = d_addr - RamBase;
   assign mmio_off  = d_addr - MmioBase;
   assign mmio_word = {mmio_off[5:2], 2'b00};
   assign idx       = ram_off[IW+1:2];

   always_comb begin
      region = REG_NONE;
      if (d_addr >= RamBase && ram_off < RAM_BYTES)
         region = REG_RAM;
      else if (d_addr >= MmioBase && mmio_off < 32'd64)
         region = REG_MMIO;
   end

   assign ram_we  = (region == REG_RAM)  && (|d_wstrb);
   assign mmio_we = (region == REG_MMIO) && (|d_wstrb);
   // An idle core parked on address 0 must not raise errors on reads
   assign err_now = (region == REG_NONE) && ((|d_wstrb) || (|d_addr[31:2]));

   // RAM has no reset; a write coinciding with reset is dropped
   always_ff @(posedge clk) begin
      if (!reset && ram_we)
         mem[idx] <= apply_wstrb(mem[idx], d_wdata, d_wstrb);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gpio_out <= '0;
         bus_err  <= 1'b0;
      end else begin
         if (mmio_we && mmio_word == MMIO_GPIO)
            gpio_out <= apply_wstrb(gpio_out, d_wdata, d_wstrb);
         bus_err <= err_now;
      end
   end

   dmem_bus_mtimer #(
      .TickDiv (TickDiv)
   ) u_mtimer (
      .clk    (clk),
      .reset  (reset),
      .we     (mmio_we),
      .offset (mmio_word),
      .wdata  (d_wdata),
      .wstrb  (d_wstrb),
      .rdata  (timer_rdata),
      .irq    (timer_irq)
   );

   always_comb begin
      d_rdata = '0;
      case (region)
         REG_RAM:  d_rdata = mem[idx];
         REG_MMIO: d_rdata = (mmio_word == MMIO_GPIO) ? gpio_out : timer_rdata;
         default:  d_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_dmem_bus.sv
// tb/tb_dmem_bus.sv - randomized and directed bench for dmem_bus against a behavioural memory map model
module tb_dmem_bus;

   localparam logic [31:0] RAM_BASE  = 32'h1000_0000;
   localparam int          RAM_WORDS = 1024;
   localparam logic [31:0] MMIO_BASE = 32'h8000_0000;
   localparam int          TICK_DIV  = 1;
   localparam int          MW        = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] d_addr, d_wdata, d_rdata, gpio_out;
   logic [3:0]  d_wstrb;
   logic        timer_irq, bus_err;

   dmem_bus #(
      .RamBase  (RAM_BASE),
      .RamWords (RAM_WORDS),
      .MmioBase (MMIO_BASE),
      .TickDiv  (TICK_DIV)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_wstrb   (d_wstrb),
      .d_rdata   (d_rdata),
      .gpio_out  (gpio_out),
      .timer_irq (timer_irq),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   // Reference model of the memory map
   logic [31:0] m_ram [MW];
   bit          m_valid [MW];
   logic [31:0] m_gpio;
   logic [63:0] m_mtime, m_cmp;
   bit          m_en, m_pend, m_err;
   int          m_div;

   function automatic bit is_ram(input logic [31:0] a);
      return (a >= RAM_BASE) && (64'(a) < 64'(RAM_BASE) + 64'(4 * RAM_WORDS));
   endfunction

   function automatic bit is_mmio(input logic [31:0] a);
      return (a >= MMIO_BASE) && (64'(a) < 64'(MMIO_BASE) + 64'd64);
   endfunction

   function automatic int ram_index(input logic [31:0] a);
      return int'((a - RAM_BASE) / 4);
   endfunction

   function automatic int mmio_reg(input logic [31:0] a);
      return int'((a - MMIO_BASE) / 4);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
      logic [31:0] mask;
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      return (o & ~mask) | (n & mask);
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (is_ram(a)) return m_ram[ram_index(a)];
      if (is_mmio(a)) begin
         case (mmio_reg(a))
            0: return m_gpio;
            1: return m_mtime[31:0];
            2: return m_mtime[63:32];
            3: return m_cmp[31:0];
            4: return m_cmp[63:32];
            5: return {31'd0, m_en};
            6: return {31'd0, m_pend};
            default: return 32'd0;
         endcase
      end
      return 32'd0;
   endfunction

   function automatic void model_reset();
      m_gpio  = '0;
      m_mtime = '0;
      m_cmp   = '1;
      m_en    = 0;
      m_pend  = 0;
      m_err   = 0;
      m_div   = 0;
   endfunction

   function automatic void model_step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
      bit          tick, set, clr;
      logic [63:0] nt;
      tick  = (m_div == TICK_DIV - 1);
      m_div = tick ? 0 : m_div + 1;
      set   = (m_mtime >= m_cmp);
      clr   = 0;
      nt    = tick ? m_mtime + 64'd1 : m_mtime;
      if (ws != 0 && is_ram(a)) begin
         m_ram[ram_index(a)] = merge(m_ram[ram_index(a)], wd, ws);
      end else if (ws != 0 && is_mmio(a)) begin
         case (mmio_reg(a))
            0: m_gpio = merge(m_gpio, wd, ws);
            1: nt = {m_mtime[63:32], merge(m_mtime[31:0], wd, ws)};
            2: nt = {merge(m_mtime[63:32], wd, ws), m_mtime[31:0]};
            3: m_cmp[31:0]  = merge(m_cmp[31:0], wd, ws);
            4: m_cmp[63:32] = merge(m_cmp[63:32], wd, ws);
            5: if (ws[0]) m_en = wd[0];
            6: clr = ws[0] && wd[0];
            default: ;
         endcase
      end
      m_mtime = nt;
      m_pend  = set || (m_pend && !clr);
      m_err   = !is_ram(a) && !is_mmio(a) && (ws != 0 || a > 32'd3);
   endfunction

   // One bus cycle: check combinational read, commit at posedge, check registered outputs
   task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      output logic [31:0] rd);
      d_addr  = a;
      d_wdata = wd;
      d_wstrb = ws;
      #1;
      rd = d_rdata;
      if (!(is_ram(a) && !m_valid[ram_index(a)])) check("rdata", d_rdata, model_read(a));
      @(posedge clk);
      model_step(a, wd, ws);
      if (ws != 0 && is_ram(a)) m_valid[ram_index(a)] = 1;
      @(negedge clk);
      check("gpio_out", gpio_out, m_gpio);
      check("timer_irq", timer_irq, m_en & m_pend);
      check("bus_err", bus_err, m_err);
   endtask

   task automatic do_reset();
      d_addr  = '0;
      d_wdata = '0;
      d_wstrb = '0;
      reset   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   logic [31:0] rd, a, wd;
   logic [3:0]  ws;

   initial begin
      for (int i = 0; i < MW; i++) m_valid[i] = 0;
      reset   = 1'b1;
      d_addr  = '0;
      d_wdata = '0;
      d_wstrb = '0;
      model_reset();
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_gpio", gpio_out, 0);
      check("rst_irq", timer_irq, 0);
      check("rst_bus_err", bus_err, 0);
      d_addr = MMIO_BASE + 32'h0C; #1 check("rst_cmp_lo", d_rdata, 32'hFFFF_FFFF);
      d_addr = MMIO_BASE + 32'h10; #1 check("rst_cmp_hi", d_rdata, 32'hFFFF_FFFF);
      d_addr = MMIO_BASE + 32'h04; #1 check("rst_mtime_lo", d_rdata, 0);
      d_addr = MMIO_BASE + 32'h14; #1 check("rst_ctrl", d_rdata, 0);
      d_addr = '0;
      @(negedge clk);
      reset = 1'b0;
      model_reset();

      // Fill the RAM words the bench uses
      for (int i = 0; i < MW; i++) bus(RAM_BASE + 32'(4 * i), $urandom, 4'hF, rd);

      // Byte-strobed RAM write
      bus(RAM_BASE + 32'h8, 32'hDEAD_BEEF, 4'hF, rd);
      bus(RAM_BASE + 32'h8, 32'h0000_5500, 4'b0010, rd);
      bus(RAM_BASE + 32'h8, 32'h0, 4'h0, rd);
      check("ram_lane_merge", rd, 32'hDEAD_55EF);

      // GPIO lane write
      bus(MMIO_BASE, 32'h0000_00A5, 4'b0001, rd);
      check("gpio_write", gpio_out, 32'h0000_00A5);

      // Read during write
      bus(RAM_BASE + 32'h4, 32'h1111_1111, 4'hF, rd);
      bus(RAM_BASE + 32'h4, 32'h2222_2222, 4'hF, rd);
      check("rdw_old", rd, 32'h1111_1111);
      bus(RAM_BASE + 32'h4, 32'h0, 4'h0, rd);
      check("rdw_new", rd, 32'h2222_2222);

      // Unmapped read pulses bus_err once; empty MMIO offset is silent
      bus(32'h4000_0000, 32'h0, 4'h0, rd);
      check("unmapped_rdata", rd, 0);
      check("bus_err_pulse", bus_err, 1);
      bus(32'h0, 32'h0, 4'h0, rd);
      check("bus_err_one_cycle", bus_err, 0);
      bus(MMIO_BASE + 32'h3C, 32'h0, 4'h0, rd);
      check("mmio_hole_rdata", rd, 0);
      check("mmio_hole_no_err", bus_err, 0);

      // Timer compare and interrupt
      do_reset();
      bus(MMIO_BASE + 32'h10, 32'h0, 4'hF, rd);
      bus(MMIO_BASE + 32'h0C, 32'd10, 4'hF, rd);
      bus(MMIO_BASE + 32'h14, 32'h1, 4'hF, rd);
      for (int i = 0; i < 40 && !timer_irq; i++) bus(32'h0, 32'h0, 4'h0, rd);
      check("irq_rise", timer_irq, 1);
      bus(MMIO_BASE + 32'h18, 32'h1, 4'hF, rd);
      bus(MMIO_BASE + 32'h18, 32'h0, 4'h0, rd);
      check("w1c_set_wins", rd, 1);
      bus(MMIO_BASE + 32'h0C, 32'hFFFF_FFFF, 4'hF, rd);
      bus(MMIO_BASE + 32'h18, 32'h1, 4'hF, rd);
      check("w1c_clear_irq", timer_irq, 0);
      bus(MMIO_BASE + 32'h18, 32'h0, 4'h0, rd);
      check("w1c_clear_pending", rd, 0);

      // Carry from low to high half
      bus(MMIO_BASE + 32'h04, 32'hFFFF_FFFF, 4'hF, rd);
      bus(MMIO_BASE + 32'h08, 32'h0, 4'hF, rd);
      bus(32'h0, 32'h0, 4'h0, rd);
      bus(32'h0, 32'h0, 4'h0, rd);
      bus(MMIO_BASE + 32'h04, 32'h0, 4'h0, rd);
      check("carry_lo", rd, 1);
      bus(MMIO_BASE + 32'h08, 32'h0, 4'h0, rd);
      check("carry_hi", rd, 1);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         ws = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
         wd = $urandom;
         case ($urandom_range(0, 2))
            0: a = RAM_BASE + 32'(4 * $urandom_range(0, MW - 1)) + 32'($urandom_range(0, 3));
            1: a = MMIO_BASE + 32'($urandom_range(0, 63));
            default: a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3))
                                                     : (32'h4000_0000 | ($urandom & 32'h0FFF_FFFF));
         endcase
         bus(a, wd, ws, rd);
      end

      // Asynchronous reset mid-run aborts a RAM write in flight
      bus(MMIO_BASE, 32'h1234_5678, 4'hF, rd);
      d_addr  = RAM_BASE + 32'h8;
      d_wdata = 32'hCAFE_F00D;
      d_wstrb = 4'hF;
      #2 reset = 1'b1;
      #1;
      check("async_rst_gpio", gpio_out, 0);
      check("async_rst_irq", timer_irq, 0);
      @(posedge clk);
      @(negedge clk);
      d_wstrb = 4'h0;
      reset   = 1'b0;
      model_reset();
      bus(RAM_BASE + 32'h8, 32'h0, 4'h0, rd);
      check("rst_abort_write", rd, m_ram[2]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
